// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last
// cycle of each bit period. Held at zero while clear is high.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

    assign bit_tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and serialises each byte as a UART
// frame (start, 8 data LSB first, optional parity, 1 or 2 stop bits).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [UART_DATA_W-1:0] fifo_data,
    output logic                   fifo_rd_en,
    input  logic                   tx_enable,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frames_sent
);

    tx_state_t              state;
    logic [UART_DATA_W-1:0] shreg;
    logic                   parity_bit;
    logic [2:0]             bit_idx;
    logic                   stop_idx;
    logic                   bit_tick;
    logic                   timer_clear;
    logic                   last_stop;
    logic                   start_ok;

    // The timer only runs while a frame is on the line; LOAD leaves it at zero.
    assign timer_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);
    assign last_stop   = (stop_idx == 1'(STOP_BITS - 1));
    assign start_ok    = tx_enable && !fifo_empty;
    assign frame_done  = (state == STOP) && bit_tick && last_stop;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            fifo_rd_en  <= 1'b0;
            busy        <= 1'b0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            frames_sent <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg      <= fifo_data;
                    parity_bit <= calc_parity(fifo_data, PARITY_ODD);
                    bit_idx    <= '0;
                    stop_idx   <= 1'b0;
                    tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    // tx is registered, so each bit is presented one boundary ahead.
                    if (bit_tick) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (last_stop) begin
                            frames_sent <= frames_sent + 16'd1;
                            if (start_ok) begin
                                state      <= FETCH;
                                fifo_rd_en <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
